// File: rtl/chamber_timer.sv
// chamber_timer: responder for the airlock wait/fill/drain start/done
// handshake. It times the requested interval in minutes from a cycle
// prescaler and drives the pump enables while that interval runs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no request active; captures the highest-priority start
// RUN   | interval counting; pump of the selected channel enabled
// DONE  | interval complete; done of the selected channel held high
module chamber_timer #(
  parameter int CYCLES_PER_MIN = 4,
  parameter int WAIT_MIN       = 5,
  parameter int FILL_MIN       = 7,
  parameter int DRAIN_MIN      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wait_start,
  input  logic       fill_start,
  input  logic       drain_start,
  output logic       wait_done,
  output logic       fill_done,
  output logic       drain_done,
  output logic       fill_pump,
  output logic       drain_pump,
  output logic       busy,
  output logic [3:0] min_left,
  output logic       conflict
);

  localparam int PW = (CYCLES_PER_MIN > 1) ? $clog2(CYCLES_PER_MIN) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_MIN - 1);

  localparam logic [3:0] WAIT_N  = 4'(WAIT_MIN);
  localparam logic [3:0] FILL_N  = 4'(FILL_MIN);
  localparam logic [3:0] DRAIN_N = 4'(DRAIN_MIN);

  localparam logic [1:0] SEL_NONE  = 2'd0;
  localparam logic [1:0] SEL_WAIT  = 2'd1;
  localparam logic [1:0] SEL_FILL  = 2'd2;
  localparam logic [1:0] SEL_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    sel;
  logic [PW-1:0] presc;

  logic          start_sel;
  logic [1:0]    start_count;
  logic [1:0]    cap_sel;
  logic [3:0]    cap_min;

  // Request of the channel currently owned; other channels are ignored
  // until the block returns to IDLE.
  always_comb begin
    start_sel = 1'b0;
    case (sel)
      SEL_WAIT:  start_sel = wait_start;
      SEL_FILL:  start_sel = fill_start;
      SEL_DRAIN: start_sel = drain_start;
      default:   start_sel = 1'b0;
    endcase
  end

  assign start_count = {1'b0, wait_start} + {1'b0, fill_start} + {1'b0, drain_start};

  // Priority pick for a capture in IDLE: wait > fill > drain.
  always_comb begin
    cap_sel = SEL_NONE;
    cap_min = 4'd0;
    if (wait_start) begin
      cap_sel = SEL_WAIT;
      cap_min = WAIT_N;
    end else if (fill_start) begin
      cap_sel = SEL_FILL;
      cap_min = FILL_N;
    end else if (drain_start) begin
      cap_sel = SEL_DRAIN;
      cap_min = DRAIN_N;
    end
  end

  // Sequencer with all outputs registered so pumps and dones never glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      sel        <= SEL_NONE;
      presc      <= '0;
      min_left   <= 4'd0;
      wait_done  <= 1'b0;
      fill_done  <= 1'b0;
      drain_done <= 1'b0;
      fill_pump  <= 1'b0;
      drain_pump <= 1'b0;
      busy       <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_count != 2'd0) begin
            state      <= ST_RUN;
            sel        <= cap_sel;
            min_left   <= cap_min;
            presc      <= '0;
            busy       <= 1'b1;
            fill_pump  <= (cap_sel == SEL_FILL);
            drain_pump <= (cap_sel == SEL_DRAIN);
            if (start_count >= 2'd2) conflict <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!start_sel) begin
            // Requester withdrew: abort silently, no done.
            state      <= ST_IDLE;
            sel        <= SEL_NONE;
            min_left   <= 4'd0;
            presc      <= '0;
            busy       <= 1'b0;
            fill_pump  <= 1'b0;
            drain_pump <= 1'b0;
          end else if (presc == PRESC_LAST) begin
            presc    <= '0;
            min_left <= min_left - 4'd1;
            if (min_left == 4'd1) begin
              state      <= ST_DONE;
              fill_pump  <= 1'b0;
              drain_pump <= 1'b0;
              wait_done  <= (sel == SEL_WAIT);
              fill_done  <= (sel == SEL_FILL);
              drain_done <= (sel == SEL_DRAIN);
            end
          end else begin
            presc <= presc + PW'(1);
          end
        end

        ST_DONE: begin
          // Done is held until the requester drops its start.
          if (!start_sel) begin
            state      <= ST_IDLE;
            sel        <= SEL_NONE;
            busy       <= 1'b0;
            wait_done  <= 1'b0;
            fill_done  <= 1'b0;
            drain_done <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          sel   <= SEL_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chamber_timer.sv
// Self-checking bench for chamber_timer: directed scenarios plus a random
// start/drop soak compared against a transaction-level timing model.
module tb_chamber_timer;

  localparam int C  = 4;
  localparam int WM = 5;
  localparam int FM = 7;
  localparam int DM = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wait_start = 1'b0;
  logic       fill_start = 1'b0;
  logic       drain_start = 1'b0;
  logic       wait_done, fill_done, drain_done;
  logic       fill_pump, drain_pump, busy, conflict;
  logic [3:0] min_left;

  int errors = 0;
  int checks = 0;

  chamber_timer #(
    .CYCLES_PER_MIN(C),
    .WAIT_MIN(WM),
    .FILL_MIN(FM),
    .DRAIN_MIN(DM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wait_start(wait_start),
    .fill_start(fill_start),
    .drain_start(drain_start),
    .wait_done(wait_done),
    .fill_done(fill_done),
    .drain_done(drain_done),
    .fill_pump(fill_pump),
    .drain_pump(drain_pump),
    .busy(busy),
    .min_left(min_left),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  // Model: owning channel (0 none, 1 wait, 2 fill, 3 drain), capture edge
  // index, completion flag, sticky conflict. Remaining minutes follow from
  // elapsed edges by division.
  int m_ch   = 0;
  int m_t0   = 0;
  bit m_done = 1'b0;
  bit m_conf = 1'b0;
  int cyc    = 0;

  function automatic int dur(int ch);
    case (ch)
      1:       return WM;
      2:       return FM;
      3:       return DM;
      default: return 0;
    endcase
  endfunction

  function automatic bit start_of(int ch);
    case (ch)
      1:       return wait_start;
      2:       return fill_start;
      3:       return drain_start;
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    m_ch   = 0;
    m_done = 1'b0;
    m_conf = 1'b0;
  endfunction

  function automatic void model_edge();
    int n;
    cyc++;
    n = int'(wait_start) + int'(fill_start) + int'(drain_start);
    if (m_ch == 0) begin
      if (n > 0) begin
        m_ch   = wait_start ? 1 : (fill_start ? 2 : 3);
        m_t0   = cyc;
        m_done = 1'b0;
        if (n > 1) m_conf = 1'b1;
      end
    end else if (!start_of(m_ch)) begin
      m_ch   = 0;
      m_done = 1'b0;
    end else if (!m_done && (cyc - m_t0) == dur(m_ch) * C) begin
      m_done = 1'b1;
    end
  endfunction

  function automatic logic [10:0] exp_vec();
    bit run;
    int ml;
    run = (m_ch != 0) && !m_done;
    ml  = run ? dur(m_ch) - (cyc - m_t0) / C : 0;
    return {m_done && m_ch == 1, m_done && m_ch == 2, m_done && m_ch == 3,
            run && m_ch == 2, run && m_ch == 3, m_ch != 0, m_conf, 4'(ml)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {wait_done, fill_done, drain_done, fill_pump, drain_pump,
            busy, conflict, min_left};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #12;
    model_reset();
    checks++;
    if (dut_vec() !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", dut_vec(), 11'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || min_left !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b min_left=%0d want 0 0", busy, min_left);
    end
  endtask

  task automatic test_wait_basic();
    int n;
    wait_start = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1 || min_left !== 4'd5) begin
      errors++;
      $display("FAIL wait_capture busy=%b min_left=%0d want 1 5", busy, min_left);
    end
    n = 0;
    while (wait_done !== 1'b1 && n < 40) begin
      step();
      n++;
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wait_track n=%0d got=%b want=%b", n, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL wait_latency got=%0d want=20", n);
    end
    wait_start = 1'b0;
    step();
    checks++;
    if (wait_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_release done=%b busy=%b want 0 0", wait_done, busy);
    end
  endtask

  task automatic test_fill_hold();
    int n;
    fill_start = 1'b1;
    step();
    n = 0;
    while (fill_pump === 1'b1 && n < 40) begin
      n++;
      step();
    end
    checks++;
    if (n != 28 || fill_done !== 1'b1 || fill_pump !== 1'b0) begin
      errors++;
      $display("FAIL fill_pump_len got=%0d done=%b pump=%b want 28 1 0", n, fill_done, fill_pump);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (fill_done !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL fill_hold i=%0d done=%b busy=%b want 1 1", i, fill_done, busy);
      end
    end
    fill_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_drain_abort();
    drain_start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (drain_pump !== 1'b1 || drain_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_run i=%0d pump=%b done=%b want 1 0", i, drain_pump, drain_done);
      end
    end
    drain_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || min_left !== 4'd0 || drain_pump !== 1'b0 || drain_done !== 1'b0) begin
        errors++;
        $display("FAIL drain_abort busy=%b min_left=%0d pump=%b done=%b want 0 0 0 0",
                 busy, min_left, drain_pump, drain_done);
      end
    end
  endtask

  task automatic test_conflict();
    int n;
    wait_start  = 1'b1;
    drain_start = 1'b1;
    step();
    checks++;
    if (conflict !== 1'b1 || min_left !== 4'd5 || drain_pump !== 1'b0) begin
      errors++;
      $display("FAIL conflict_capture conflict=%b min_left=%0d dpump=%b want 1 5 0",
               conflict, min_left, drain_pump);
    end
    n = 0;
    while (wait_done !== 1'b1 && n < 40) begin
      step();
      n++;
      checks++;
      if (drain_pump !== 1'b0 || drain_done !== 1'b0 || conflict !== 1'b1) begin
        errors++;
        $display("FAIL conflict_ignore n=%0d dpump=%b ddone=%b conflict=%b want 0 0 1",
                 n, drain_pump, drain_done, conflict);
      end
    end
    checks++;
    if (n != 20) begin
      errors++;
      $display("FAIL conflict_wait_latency got=%0d want=20", n);
    end
    wait_start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || wait_done !== 1'b0 || conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_gap busy=%b wdone=%b conflict=%b want 0 0 1", busy, wait_done, conflict);
    end
    step();
    checks++;
    if (drain_pump !== 1'b1 || min_left !== 4'd8) begin
      errors++;
      $display("FAIL conflict_drain_capture dpump=%b min_left=%0d want 1 8", drain_pump, min_left);
    end
    drain_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_async_reset();
    int n;
    fill_start = 1'b1;
    repeat (15) step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 11'b0) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", dut_vec(), 11'b0);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    n = 0;
    while (fill_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (n != 28) begin
      errors++;
      $display("FAIL fill_after_reset got=%0d want=28", n);
    end
    fill_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_fill_during_wait();
    int n;
    wait_start = 1'b1;
    step();
    repeat (5) step();
    fill_start = 1'b1;
    n = 6;
    while (wait_done !== 1'b1 && n < 40) begin
      step();
      n++;
      checks++;
      if (fill_pump !== 1'b0) begin
        errors++;
        $display("FAIL fill_leak n=%0d fpump=%b want 0", n, fill_pump);
      end
    end
    checks++;
    if (n != 21) begin
      errors++;
      $display("FAIL wait_undisturbed got=%0d want=21", n);
    end
    wait_start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || fill_pump !== 1'b0) begin
      errors++;
      $display("FAIL fill_gap busy=%b fpump=%b want 0 0", busy, fill_pump);
    end
    step();
    checks++;
    if (fill_pump !== 1'b1 || min_left !== 4'd7) begin
      errors++;
      $display("FAIL fill_capture fpump=%b min_left=%0d want 1 7", fill_pump, min_left);
    end
    fill_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) wait_start  = ~wait_start;
      if ($urandom_range(0, 29) == 0) fill_start  = ~fill_start;
      if ($urandom_range(0, 29) == 0) drain_start = ~drain_start;
      step();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%b want=%b", cyc, dut_vec(), exp_vec());
      end
    end
    wait_start  = 1'b0;
    fill_start  = 1'b0;
    drain_start = 1'b0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_wait_basic();
    test_fill_hold();
    test_drain_abort();
    test_conflict();
    test_async_reset();
    test_fill_during_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chamber_timer.md
Name: chamber_timer

Overview:
- Responder side of the airlock start/done handshake. Receives wait_start, fill_start and drain_start from the chamber-control FSM.
- Times the requested interval in minutes from a cycle prescaler, drives the fill/drain pump enables, and returns a level done signal on the matching channel.
- Sits beside the control FSM. Its done outputs feed that FSM's wait_done, fill_done and drain_done inputs directly.

Parameters:
CYCLES_PER_MIN, 4, clk cycles per timed minute (board build overrides to 3_000_000_000 / clock divisor; must be >= 2)
WAIT_MIN, 5, wait-channel duration in minutes (1..15)
FILL_MIN, 7, fill-channel duration in minutes (1..15)
DRAIN_MIN, 8, drain-channel duration in minutes (1..15)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
wait_start  input  1  level request for the wait interval, held by the requester until done is seen
fill_start  input  1  level request for the fill interval
drain_start  input  1  level request for the drain interval
wait_done  output  1  level; wait interval complete
fill_done  output  1  level; fill interval complete
drain_done  output  1  level; drain interval complete
fill_pump  output  1  high while the fill interval is running
drain_pump  output  1  high while the drain interval is running
busy  output  1  high in RUN or DONE
min_left  output  4  minutes remaining in the active interval; 0 when idle or done
conflict  output  1  sticky; set when more than one start is high in IDLE

Behaviour:
- Reset (reset low, asynchronous) clears everything:
  - state = IDLE, sel = none, prescaler = 0, min_left = 0
  - all done outputs = 0, pumps = 0, busy = 0, conflict = 0
- A reset asserted mid-interval aborts with no done.
- States: IDLE, RUN, DONE. sel is a 2-bit channel register (none/wait/fill/drain).
- IDLE:
  - At the first rising edge with any start high: state <= RUN.
  - sel <= highest-priority asserted channel (wait > fill > drain).
  - min_left <= that channel's duration, prescaler <= 0.
  - If two or more starts are high on that edge, conflict <= 1.
- RUN, start[sel] still high:
  - prescaler increments each cycle.
  - When prescaler == CYCLES_PER_MIN-1: prescaler <= 0 and min_left <= min_left-1.
  - If min_left == 1 on that edge: state <= DONE and done[sel] <= 1.
  - Net latency: done[sel] rises exactly N*CYCLES_PER_MIN cycles after the capturing edge (N = channel minutes).
- RUN, start[sel] low (requester abort): state <= IDLE, min_left <= 0, prescaler <= 0, no done pulse.
- DONE:
  - done[sel] is held high for as long as start[sel] stays high. The requester may wait an unbounded time (e.g. for an arrive/depart qualifier).
  - At the first edge with start[sel] low: done[sel] <= 0, state <= IDLE, sel <= none.
- Starts on non-selected channels are ignored in RUN and DONE. They are captured only after the return to IDLE.
- Minimum gap after done: one IDLE cycle separates a dropped start from the next capture, so a new request is captured no earlier than 2 edges after start[sel] falls.
- Output derivations:
  - fill_pump = (state==RUN && sel==fill); drain_pump = (state==RUN && sel==drain); both decoded from registers only, glitch-free.
  - busy = (state != IDLE).
  - At most one done output is ever high.
- Width rules: min_left is 4-bit unsigned. Prescaler width is clog2(CYCLES_PER_MIN). No wrap: min_left never decrements below 1 in RUN.
- conflict is cleared only by reset.

Test Plan:
- Reset, then wait_start=1 held (CYCLES_PER_MIN=4) -> busy=1 and min_left=5 next cycle; min_left steps 4,3,2,1 every 4 cycles; wait_done=1 exactly 20 cycles after the capture edge. Then drop wait_start -> wait_done=0 and busy=0 one edge later.
- fill_start held -> fill_pump=1 for exactly 28 cycles, then fill_done=1 with fill_pump=0. Hold fill_start 10 further cycles -> fill_done stays 1 throughout.
- drain_start held 12 cycles, then dropped -> state IDLE, min_left=0, drain_pump=0, drain_done never asserted.
- wait_start and drain_start rise on the same edge -> wait channel selected, conflict=1 and stays 1 through the full cycle. drain_start is ignored until wait completes and returns to IDLE.
- Reset pulled low at cycle 15 of a fill -> all outputs 0 immediately (asynchronous). After release with fill_start high -> fresh 28-cycle interval.
- fill_start raised while a wait is running -> no effect on wait timing; fill is captured 2 edges after wait_start drops.
